avalon_pio_in_edge: RTL and testbench

Parametrised Avalon-MM input PIO, the successor of the fixed 2-bit read-only PIO. It samples WIDTH external input lines through a configurable synchroniser. It also detects edges per bit, latches them in an edge-capture register, and raises a maskable level interrupt. It sits on the SOPC system interconnect as an Avalon slave with a 2-bit word address and a 32-bit data bus.

---
 rtl/avalon_pio_pkg.sv | 13 +
 rtl/pio_in_sync.sv | 32 +++
 rtl/avalon_pio_in_edge.sv | 114 +++++++++++
 tb/tb_avalon_pio_in_edge.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared register map and edge-type encodings for the Avalon input PIO.
package avalon_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_in_sync.sv
// Multi-stage flop synchroniser for asynchronous input lines; q is the last stage.
module pio_in_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d[0] = d;
    for (int s = 1; s < STAGES; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM input PIO with synchronised inputs, per-bit edge capture and a maskable level irq.
module avalon_pio_in_edge
  import avalon_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter int          BIT_CLEAR   = 1,
  parameter logic [31:0] MASK_RESET  = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             CNT_W     = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] prev_sync_q, prev_sync_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [CNT_W-1:0] warm_q, warm_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] clr;
  logic             wr_en;
  logic             wdata_unused;

  pio_in_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (data_sync)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == EDGE_RISING) begin : g_rise
        assign edge_raw[gi] = data_sync[gi] & ~prev_sync_q[gi];
      end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
        assign edge_raw[gi] = ~data_sync[gi] & prev_sync_q[gi];
      end else begin : g_any
        assign edge_raw[gi] = data_sync[gi] ^ prev_sync_q[gi];
      end
    end
  endgenerate

  assign wr_en        = chipselect & ~write_n;
  assign wdata_unused = ^writedata;

  always_comb begin
    prev_sync_d = data_sync;
    warm_d      = (warm_q == WARM_DONE) ? warm_q : warm_q + CNT_W'(1);
    // Lines already high out of reset would look like edges until the pipeline fills.
    edge_event  = (warm_q == WARM_DONE) ? edge_raw : '0;

    clr = '0;
    if (wr_en && address == ADDR_EDGECAP) begin
      clr = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
    end
    edge_cap_d = (edge_cap_q & ~clr) | edge_event;

    irq_mask_d = irq_mask_q;
    if (wr_en && address == ADDR_IRQMASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end

    irq_d = |(edge_cap_q & irq_mask_q);

    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = data_sync;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sync_q <= '0;
      warm_q      <= '0;
      edge_cap_q  <= '0;
      irq_mask_q  <= MASK_RESET[WIDTH-1:0];
      irq_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      prev_sync_q <= prev_sync_d;
      warm_q      <= warm_d;
      edge_cap_q  <= edge_cap_d;
      irq_mask_q  <= irq_mask_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Directed bench: a rising-edge and a falling-edge instance share one Avalon bus.
module tb_avalon_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [7:0]  in_r = 8'hFF;
  logic [7:0]  in_f = 8'h00;
  logic [31:0] rd_r, rd_f;
  logic        irq_r, irq_f;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  avalon_pio_in_edge #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .BIT_CLEAR(1), .MASK_RESET(32'h0)
  ) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_r),
    .readdata(rd_r), .irq(irq_r)
  );

  avalon_pio_in_edge #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .BIT_CLEAR(1), .MASK_RESET(32'h0)
  ) dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_f),
    .readdata(rd_f), .irq(irq_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("write addr=%0d data=0x%0h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    @(negedge clk);
    $display("read  addr=%0d rise=0x%0h fall=0x%0h irq_r=%0b irq_f=%0b", a, rd_r, rd_f, irq_r, irq_f);
  endtask

  initial begin
    // 1: reset with inputs high, warm-up must hide the false rising edges
    idle(3);
    check("rst_rd_r", rd_r, 32'h0);
    check("rst_irq_r", {31'h0, irq_r}, 32'h0);
    check("rst_rd_f", rd_f, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_irq_quiet", {31'h0, irq_r}, 32'h0);
    end
    bus_read(2'd0); check("t1_data", rd_r, 32'h0000_00FF);
    bus_read(2'd3); check("t1_cap_zero", rd_r, 32'h0);
    bus_read(2'd2); check("t1_mask_rst", rd_r, 32'h0);

    // reserved and DATA registers ignore writes
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1); check("rsvd_zero", rd_r, 32'h0);
    bus_write(2'd0, 32'h0);
    bus_read(2'd0); check("data_ro", rd_r, 32'h0000_00FF);

    // 2: latency of edge capture and irq
    in_r = 8'h00;
    idle(5);
    bus_write(2'd2, 32'h01);
    address = 2'd3;
    in_r    = 8'h01;
    idle(3);
    check("t2_cap_early", rd_r, 32'h0);
    check("t2_irq_early", {31'h0, irq_r}, 32'h0);
    idle(1);
    check("t2_cap", rd_r, 32'h01);
    check("t2_irq", {31'h0, irq_r}, 32'h1);

    // 3: per-bit write-1-to-clear
    in_r = 8'h09;
    idle(6);
    bus_read(2'd3); check("t3_cap09", rd_r, 32'h09);
    bus_write(2'd3, 32'h08);
    bus_read(2'd3); check("t3_cap01", rd_r, 32'h01);
    check("t3_irq_on", {31'h0, irq_r}, 32'h1);
    bus_write(2'd3, 32'h01);
    check("t3_irq_lag", {31'h0, irq_r}, 32'h1);
    idle(1);
    check("t3_irq_off", {31'h0, irq_r}, 32'h0);
    bus_read(2'd3); check("t3_cap_clr", rd_r, 32'h0);

    // 4: clear and new edge on bit 2 in the same cycle, set wins
    in_r = 8'h0D;
    idle(2);
    bus_write(2'd3, 32'h04);
    bus_read(2'd3); check("t4_set_wins", rd_r, 32'h04);

    // 5: falling-edge instance
    bus_write(2'd2, 32'h20);
    in_f = 8'h20;
    idle(6);
    bus_read(2'd3); check("t5_rise_ignored", rd_f, 32'h0);
    check("t5_irq_none", {31'h0, irq_f}, 32'h0);
    in_f = 8'h00;
    idle(6);
    bus_read(2'd3); check("t5_fall_cap", rd_f, 32'h20);
    check("t5_fall_irq", {31'h0, irq_f}, 32'h1);

    // 6: mid-operation reset with everything set
    bus_write(2'd2, 32'hFF);
    in_r = 8'h00;
    idle(5);
    in_r = 8'hFF;
    idle(6);
    bus_read(2'd3); check("t6_cap_ff", rd_r, 32'hFF);
    check("t6_irq_on", {31'h0, irq_r}, 32'h1);
    bus_read(2'd2); check("t6_mask_ff", rd_r, 32'hFF);
    reset = 1'b1;
    idle(1);
    check("t6_rst_rd", rd_r, 32'h0);
    check("t6_rst_irq_r", {31'h0, irq_r}, 32'h0);
    check("t6_rst_irq_f", {31'h0, irq_f}, 32'h0);
    reset = 1'b0;
    bus_read(2'd2); check("t6_mask_rst", rd_r, 32'h0);
    bus_read(2'd3); check("t6_cap_rst", rd_r, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
